// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice.
//   REG_ZERO    : index of the hardwired-zero register.
//   NRP_MAX     : largest supported number of read ports.
//   rport_sel_t : packed per-read-port flag vector at maximum port count.
//   aw()        : address width for a given register count.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int NRP_MAX  = 4;

  typedef logic [NRP_MAX-1:0] rport_sel_t;

  // Guards against a zero-width index when only one register is requested.
  function automatic int aw(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the register file.
//   rs_addr/rs_data/rs_busy : combinational read ports
//   iss_valid/iss_rd        : destination claim from decode
//   wb_valid/wb_rd/wb_data  : writeback strobe
//   pend_cnt/drained/err    : scoreboard status
// master = decode/writeback side, slave = register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRP  = 2
) ();

  localparam int AW = aw(NREG);

  logic [NRP-1:0][AW-1:0]   rs_addr;
  logic [NRP-1:0][XLEN-1:0] rs_data;
  logic [NRP-1:0]           rs_busy;
  logic                     iss_valid;
  logic [AW-1:0]            iss_rd;
  logic                     wb_valid;
  logic [AW-1:0]            wb_rd;
  logic [XLEN-1:0]          wb_data;
  logic [AW:0]              pend_cnt;
  logic                     drained;
  logic                     err;

  modport master (
    output rs_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
    input  rs_data, rs_busy, pend_cnt, drained, err
  );

  modport slave (
    input  rs_addr, iss_valid, iss_rd, wb_valid, wb_rd, wb_data,
    output rs_data, rs_busy, pend_cnt, drained, err
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one pending bit per register, a running count
// of pending registers, a sticky error for unclaimed writebacks, and the
// raw pending lookup for each read port.
//   clk, rst      : clock, asynchronous active-low reset
//   iss_valid_i/iss_rd_i : claim
//   wb_valid_i/wb_rd_i   : writeback (clears pending)
//   rs_addr_i     : read-port indices
//   busy_o        : pending bit of each read-port register
//   pend_cnt_o, drained_o, err_o : status
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int AW   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid_i,
  input  logic [AW-1:0]          iss_rd_i,
  input  logic                   wb_valid_i,
  input  logic [AW-1:0]          wb_rd_i,
  input  logic [NRP-1:0][AW-1:0] rs_addr_i,
  output logic [NRP-1:0]         busy_o,
  output logic [AW:0]            pend_cnt_o,
  output logic                   drained_o,
  output logic                   err_o
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            claim, wback, inc, dec;

  always_comb begin
    claim     = iss_valid_i && (iss_rd_i != AW'(REG_ZERO));
    wback     = wb_valid_i  && (wb_rd_i  != AW'(REG_ZERO));
    pending_d = pending_q;
    // Clear first, then set: a claim on the same edge supersedes the writeback.
    if (wback) pending_d[wb_rd_i]  = 1'b0;
    if (claim) pending_d[iss_rd_i] = 1'b1;
    inc   = claim && !pending_q[iss_rd_i];
    // A writeback to a register re-claimed on the same edge leaves it pending.
    dec   = wback && pending_q[wb_rd_i] && !(claim && (iss_rd_i == wb_rd_i));
    cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    err_d = err_q | (wback && !pending_q[wb_rd_i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      busy_o[p] = pending_q[rs_addr_i[p]];
    end
  end

  assign pend_cnt_o = cnt_q;
  assign drained_o  = (cnt_q == '0);
  assign err_o      = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with hardwired-zero x0, optional same-cycle
// writeback forwarding and an integrated pending-write scoreboard.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : regfile_sb_if.slave (read ports, claim, writeback, status)
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_sb_if.slave bus
);

  localparam int AW = aw(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NRP-1:0]  busy_raw;
  logic            wr_en;

  assign wr_en = bus.wb_valid && (bus.wb_rd != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  reg_scoreboard #(
    .NREG (NREG),
    .NRP  (NRP),
    .AW   (AW)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (bus.iss_valid),
    .iss_rd_i    (bus.iss_rd),
    .wb_valid_i  (bus.wb_valid),
    .wb_rd_i     (bus.wb_rd),
    .rs_addr_i   (bus.rs_addr),
    .busy_o      (busy_raw),
    .pend_cnt_o  (bus.pend_cnt),
    .drained_o   (bus.drained),
    .err_o       (bus.err)
  );

  // x0 masking takes priority; forwarding overrides the pending bit because
  // the value being read is the one that resolves it.
  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      bus.rs_data[p] = regs_q[bus.rs_addr[p]];
      bus.rs_busy[p] = busy_raw[p];
      if (bus.rs_addr[p] == AW'(REG_ZERO)) begin
        bus.rs_data[p] = '0;
        bus.rs_busy[p] = 1'b0;
      end else if ((BYPASS != 0) && bus.wb_valid && (bus.wb_rd == bus.rs_addr[p])) begin
        bus.rs_data[p] = bus.wb_data;
        bus.rs_busy[p] = 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with write-through bypass, a hardwired-zero register 0 and an integrated pending-write scoreboard. It sits in the CPU decode/writeback stage and generalises the original 32×64, 2-read register group. Changes from that block: configurable width, depth and read-port count; same-cycle forwarding; per-register busy tracking so decode can stall on read-after-write hazards.

## Interface
Parameters:
- XLEN, 64, data width in bits.
- NREG, 32, number of registers; power of two, ≥ 2; AW = $clog2(NREG).
- NRP, 2, number of read ports, 1..4.
- BYPASS, 1, 1 = forward same-cycle writeback data to the read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- rs_addr  in  [NRP][AW]  read-port register indices.
- rs_data  out  [NRP][XLEN]  read data, combinational.
- rs_busy  out  [NRP]  register has an outstanding claimed write.
- iss_valid  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  AW  destination being claimed.
- wb_valid  in  1  writeback strobe (the original we_reg).
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- pend_cnt  out  AW+1  number of registers currently pending.
- drained  out  1  pend_cnt == 0.
- err  out  1  sticky flag: writeback to a non-pending, nonzero register.

## Operation
- Reset (rst low, async): all registers 0; all pending bits 0; pend_cnt 0; err 0. Outputs after reset: rs_data 0, rs_busy 0, drained 1.
- Register 0:
  - always reads 0 and is never busy.
  - writes and claims to 0 are dropped silently.
  - register 0 never sets err.
- Write: on a clk edge with wb_valid and wb_rd≠0, reg[wb_rd] ← wb_data and pending[wb_rd] is cleared.
- Claim: on a clk edge with iss_valid and iss_rd≠0, pending[iss_rd] is set.
- Simultaneous claim and writeback to the same rd:
  - data is written.
  - pending stays set, because the new claim supersedes.
  - pend_cnt is unchanged.
- Claim of an already-pending register: stays set, no count change. Back-to-back claims are not counted.
- Writeback to a non-pending nonzero register: data is written, err is set and stays set until reset.
- Read, per port p:
  - BYPASS=1 and wb_valid and wb_rd==rs_addr[p]≠0: rs_data[p] = wb_data and rs_busy[p] = 0 (forwarded; this overrides pending).
  - Otherwise rs_data[p] = reg[rs_addr[p]] and rs_busy[p] = pending[rs_addr[p]].
- pend_cnt: registered. Each edge applies +1 for a newly set bit and −1 for a newly cleared bit; a simultaneous +1 and −1 nets to zero. Its value always equals popcount(pending).

## Timing
- Read latency: 0 cycles, combinational from rs_addr / wb_*.
- Write visibility:
  - BYPASS=1: same cycle via forwarding.
  - BYPASS=0: the cycle after the edge.
- Claim visibility: rs_busy rises the cycle after the iss_valid edge.
- No handshake back-pressure. Decode must not read an rs_busy register and must hold the instruction until rs_busy falls.
- Reset asserted mid-operation clears all state immediately. In-flight writebacks arriving after reset raise err, which is expected and is for the bench to mask.

## Structure
- Shared package regfile_pkg: AW helper function, the packed read-port typedefs, and the REG_ZERO constant.
- Sub-module reg_scoreboard: pending vector, pend_cnt, err, and the busy lookup per read port. The data array, bypass muxes and x0 masking stay in regfile_sb.

## Test plan
- Reset then read all 32 registers on both ports → every rs_data = 0, rs_busy = 0, drained = 1, pend_cnt = 0.
- Claim x5, next cycle wb x5 = 0xDEADBEEF_00000001, with port0 reading x5 throughout:
  - cycle after claim: rs_busy[0] = 1.
  - wb cycle, BYPASS=1: rs_data[0] = 0xDEADBEEF_00000001 and rs_busy[0] = 0.
  - wb cycle, BYPASS=0: rs_busy[0] = 1 during the wb cycle, and the new value appears the next cycle.
- wb x0 = 0xFFFF…F with a claim of x0 → x0 reads 0, rs_busy 0, pend_cnt 0, err 0.
- Claim x7 and wb x7 on the same edge, x7 previously pending → x7 holds the new data, rs_busy stays 1, pend_cnt unchanged.
- Claim x1..x31 on consecutive cycles → pend_cnt = 31, drained 0. Write all back → pend_cnt = 0, drained 1, err 0.
- wb x9 while x9 is not pending → err = 1 and it stays 1 across further traffic. Then pull rst low mid-sequence → err, pend_cnt and registers clear asynchronously, without waiting for a clock edge.
